// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready port between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_stage_if;
   logic        O_imem_req;
   logic [15:0] O_imem_addr;
   logic        in_imem_ready;
   logic [15:0] in_imem_rdata;

   modport master (
      output O_imem_req,
      output O_imem_addr,
      input  in_imem_ready,
      input  in_imem_rdata
   );

   modport slave (
      input  O_imem_req,
      input  O_imem_addr,
      output in_imem_ready,
      output in_imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the PC, absorbs memory
// wait states, decode stalls (via a one-entry skid buffer) and branch redirects.
module if_fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_stall,
   input  logic                   in_branch_taken,
   input  logic [15:0]            in_branch_target,
   if_fetch_stage_if.master       imem,
   output logic [15:0]            O_PC_plus_two,
   output logic [15:0]            O_instruction,
   output logic                   O_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] drain_addr_q, drain_addr_d;
   logic [15:0] skid_instr_q, skid_instr_d;
   logic [15:0] skid_pc2_q, skid_pc2_d;
   logic [15:0] pc2_q, pc2_d;
   logic [15:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   logic [15:0] pc_inc;
   logic [15:0] target;
   logic        ready;

   assign pc_inc = pc_q + 16'd2;
   assign target = in_branch_target & 16'hFFFE;
   assign ready  = imem.in_imem_ready;

   // DRAIN keeps presenting the wrong-path address so it stays stable until ready.
   assign imem.O_imem_req  = (state_q != HOLD);
   assign imem.O_imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   assign O_PC_plus_two = pc2_q;
   assign O_instruction = instr_q;
   assign O_valid       = valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      skid_instr_d = skid_instr_q;
      skid_pc2_d   = skid_pc2_q;
      pc2_d        = pc2_q;
      instr_d      = instr_q;
      valid_d      = valid_q;

      case (state_q)
         FETCH: begin
            if (in_branch_taken) begin
               pc_d    = target;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               if (!ready) begin
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end
            end else if (in_stall) begin
               if (ready) begin
                  skid_instr_d = imem.in_imem_rdata;
                  skid_pc2_d   = pc_inc;
                  pc_d         = pc_inc;
                  state_d      = HOLD;
               end
            end else if (ready) begin
               pc2_d   = pc_inc;
               instr_d = imem.in_imem_rdata;
               valid_d = 1'b1;
               pc_d    = pc_inc;
            end else begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end

         HOLD: begin
            if (in_branch_taken) begin
               pc_d         = target;
               valid_d      = 1'b0;
               instr_d      = NOP_INSTR;
               skid_instr_d = NOP_INSTR;
               state_d      = FETCH;
            end else if (!in_stall) begin
               pc2_d   = skid_pc2_q;
               instr_d = skid_instr_q;
               valid_d = 1'b1;
               state_d = FETCH;
            end
         end

         DRAIN: begin
            // The in-flight response belongs to the wrong path; stall is irrelevant here.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            if (in_branch_taken) pc_d = target;
            if (ready) state_d = FETCH;
         end

         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         skid_instr_q <= NOP_INSTR;
         skid_pc2_q   <= 16'h0000;
         pc2_q        <= 16'h0000;
         instr_q      <= NOP_INSTR;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         skid_instr_q <= skid_instr_d;
         skid_pc2_q   <= skid_pc2_d;
         pc2_q        <= pc2_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage: table of per-cycle stimulus and
// expected request/IF-ID values, plus a hand sequence for async reset.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_stall = 1'b0;
   logic        in_branch_taken = 1'b0;
   logic [15:0] in_branch_target = 16'h0000;
   logic [15:0] O_PC_plus_two;
   logic [15:0] O_instruction;
   logic        O_valid;

   if_fetch_stage_if imem_bus ();

   if_fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_stall         (in_stall),
      .in_branch_taken  (in_branch_taken),
      .in_branch_target (in_branch_target),
      .imem             (imem_bus),
      .O_PC_plus_two    (O_PC_plus_two),
      .O_instruction    (O_instruction),
      .O_valid          (O_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        rdy;
      logic [15:0] rdata;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic [15:0] e_pc2;
   } vec_t;

   localparam int NV = 30;
   vec_t vecs [NV];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic vec_t mk(logic stall, logic br, logic [15:0] tgt, logic rdy,
                               logic [15:0] rdata, logic e_req, logic [15:0] e_addr,
                               logic e_valid, logic [15:0] e_instr, logic [15:0] e_pc2);
      vec_t v;
      v.stall = stall; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_pc2 = e_pc2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stall, input logic br, input logic [15:0] tgt,
                        input logic rdy, input logic [15:0] rdata);
      in_stall                = stall;
      in_branch_taken         = br;
      in_branch_target        = tgt;
      imem_bus.in_imem_ready  = rdy;
      imem_bus.in_imem_rdata  = rdata;
   endtask

   initial begin
      //                stall br  tgt      rdy rdata     req addr     valid instr    pc2
      // zero-wait memory, three back-to-back words
      vecs[0]  = mk(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 1, 16'h1111, 16'h0002);
      vecs[1]  = mk(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0002, 1, 16'h2222, 16'h0004);
      vecs[2]  = mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0004, 1, 16'h3333, 16'h0006);
      // ready every third cycle: two bubbles, address held
      vecs[3]  = mk(0, 0, 16'h0000, 0, 16'hBAD0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
      vecs[4]  = mk(0, 0, 16'h0000, 0, 16'hBAD1, 1, 16'h0006, 0, 16'h0000, 16'h0000);
      vecs[5]  = mk(0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0006, 1, 16'h4444, 16'h0008);
      // three-cycle stall arriving with ready on addr 8
      vecs[6]  = mk(1, 0, 16'h0000, 1, 16'h5555, 1, 16'h0008, 1, 16'h4444, 16'h0008);
      vecs[7]  = mk(1, 0, 16'h0000, 1, 16'hBAD2, 0, 16'h0000, 1, 16'h4444, 16'h0008);
      vecs[8]  = mk(1, 0, 16'h0000, 1, 16'hBAD3, 0, 16'h0000, 1, 16'h4444, 16'h0008);
      vecs[9]  = mk(0, 0, 16'h0000, 1, 16'hBAD4, 0, 16'h0000, 1, 16'h5555, 16'h000A);
      vecs[10] = mk(0, 0, 16'h0000, 1, 16'h6666, 1, 16'h000A, 1, 16'h6666, 16'h000C);
      vecs[11] = mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h000C, 1, 16'h7777, 16'h000E);
      vecs[12] = mk(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h000E, 1, 16'h8888, 16'h0010);
      // branch (odd target, bit 0 dropped) while fetch of 0x0010 pending
      vecs[13] = mk(0, 1, 16'h0041, 0, 16'hBAD5, 1, 16'h0010, 0, 16'h0000, 16'h0000);
      vecs[14] = mk(0, 0, 16'h0000, 0, 16'hBAD6, 1, 16'h0010, 0, 16'h0000, 16'h0000);
      vecs[15] = mk(0, 0, 16'h0000, 1, 16'hDEAD, 1, 16'h0010, 0, 16'h0000, 16'h0000);
      vecs[16] = mk(0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0040, 1, 16'h9999, 16'h0042);
      // branch coincident with stall while in HOLD
      vecs[17] = mk(1, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h0042, 1, 16'h9999, 16'h0042);
      vecs[18] = mk(1, 1, 16'h0080, 1, 16'hBAD7, 0, 16'h0000, 0, 16'h0000, 16'h0000);
      vecs[19] = mk(0, 0, 16'h0000, 1, 16'hBBBB, 1, 16'h0080, 1, 16'hBBBB, 16'h0082);
      // branch in FETCH with ready: word discarded, stay FETCH
      vecs[20] = mk(0, 1, 16'h0100, 1, 16'hCCCC, 1, 16'h0082, 0, 16'h0000, 16'h0000);
      vecs[21] = mk(0, 0, 16'h0000, 1, 16'hDDDD, 1, 16'h0100, 1, 16'hDDDD, 16'h0102);
      // stall with no ready: everything holds
      vecs[22] = mk(1, 0, 16'h0000, 0, 16'hBAD8, 1, 16'h0102, 1, 16'hDDDD, 16'h0102);
      // second branch during DRAIN overrides target; stall ignored in DRAIN
      vecs[23] = mk(0, 1, 16'h0200, 0, 16'hBAD9, 1, 16'h0102, 0, 16'h0000, 16'h0000);
      vecs[24] = mk(0, 1, 16'h0300, 0, 16'hBADA, 1, 16'h0102, 0, 16'h0000, 16'h0000);
      vecs[25] = mk(1, 0, 16'h0000, 1, 16'hBADB, 1, 16'h0102, 0, 16'h0000, 16'h0000);
      vecs[26] = mk(0, 0, 16'h0000, 1, 16'hEEEE, 1, 16'h0300, 1, 16'hEEEE, 16'h0302);
      // PC wrap at 0xFFFE
      vecs[27] = mk(0, 1, 16'hFFFE, 1, 16'hBADC, 1, 16'h0302, 0, 16'h0000, 16'h0000);
      vecs[28] = mk(0, 0, 16'h0000, 1, 16'hF00D, 1, 16'hFFFE, 1, 16'hF00D, 16'h0000);
      vecs[29] = mk(0, 0, 16'h0000, 0, 16'hBADD, 1, 16'h0000, 0, 16'h0000, 16'h0000);

      drive(0, 0, 16'h0000, 0, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {15'd0, O_valid}, 16'h0000);
      chk("rst_instr", O_instruction, 16'h0000);
      chk("rst_pc2",   O_PC_plus_two, 16'h0000);
      chk("rst_addr",  imem_bus.O_imem_addr, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].rdy, vecs[i].rdata);
         #1;
         chk($sformatf("v%0d_req", i), {15'd0, imem_bus.O_imem_req}, {15'd0, vecs[i].e_req});
         if (vecs[i].e_req)
            chk($sformatf("v%0d_addr", i), imem_bus.O_imem_addr, vecs[i].e_addr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), {15'd0, O_valid}, {15'd0, vecs[i].e_valid});
         chk($sformatf("v%0d_instr", i), O_instruction, vecs[i].e_instr);
         if (vecs[i].e_valid)
            chk($sformatf("v%0d_pc2", i), O_PC_plus_two, vecs[i].e_pc2);
      end

      // Redirect to 0x0500, fetch one word, then reset asynchronously mid-wait.
      @(negedge clk);
      drive(0, 1, 16'h0500, 1, 16'hBADE);
      @(negedge clk);
      drive(0, 0, 16'h0000, 1, 16'h1234);
      #1;
      chk("seq_addr500", imem_bus.O_imem_addr, 16'h0500);
      @(posedge clk);
      #1;
      chk("seq_valid500", {15'd0, O_valid}, 16'h0001);
      chk("seq_pc2_500",  O_PC_plus_two, 16'h0502);
      @(negedge clk);
      drive(0, 0, 16'h0000, 0, 16'h0000);
      #1;
      chk("seq_wait_addr", imem_bus.O_imem_addr, 16'h0502);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_valid", {15'd0, O_valid}, 16'h0000);
      chk("arst_instr", O_instruction, 16'h0000);
      chk("arst_pc2",   O_PC_plus_two, 16'h0000);
      chk("arst_addr",  imem_bus.O_imem_addr, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 16'h0000, 1, 16'h1111);
      #1;
      chk("post_rst_req",  {15'd0, imem_bus.O_imem_req}, 16'h0001);
      chk("post_rst_addr", imem_bus.O_imem_addr, 16'h0000);
      @(posedge clk);
      #1;
      chk("post_rst_valid", {15'd0, O_valid}, 16'h0001);
      chk("post_rst_instr", O_instruction, 16'h1111);
      chk("post_rst_pc2",   O_PC_plus_two, 16'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit MIPS core.
- Owns the PC and drives a request/ready instruction-memory port.
- Absorbs multi-cycle memory latency, ID stalls and branch redirects.
- Feeds the decode stage the fetched instruction, its PC+2 and a valid bit. Decode output flows into ID_EX.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, instruction word emitted for bubbles and flushes

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_stall  in  1  hazard unit: hold PC and IF/ID contents
in_branch_taken  in  1  branch resolved taken; redirect and flush
in_branch_target  in  16  redirect address, sampled when in_branch_taken=1
O_imem_req  out  1  instruction fetch request
O_imem_addr  out  16  fetch address (word-aligned, bit 0 = 0)
in_imem_ready  in  1  memory accepted request; data valid this cycle
in_imem_rdata  in  16  instruction word, valid when in_imem_ready=1
O_PC_plus_two  out  16  registered fetch address + 2
O_instruction  out  16  registered instruction to decode
O_valid  out  1  1 = O_instruction is a real instruction

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, skid buffer=NOP_INSTR, O_PC_plus_two=0, O_instruction=NOP_INSTR, O_valid=0.
- Memory handshake:
  - O_imem_req=1 in FETCH and DRAIN, 0 in HOLD. O_imem_addr = pc in FETCH; the latched in-flight address in DRAIN.
  - A transfer completes on an edge where O_imem_req & in_imem_ready.
  - Once req is asserted, the address stays stable until ready. Zero-wait memory (ready in the same cycle as req) is legal.
- PC arithmetic: pc+2 is 16-bit modulo; 16'hFFFE -> 16'h0000. No other PC increment.
- Latency: an instruction accepted on edge N appears on O_instruction/O_valid after edge N. Back-to-back ready gives one instruction per cycle.
- Priority per edge: rst > in_branch_taken > in_stall > normal.
- States: FETCH, HOLD (fetched word buffered while stalled), DRAIN (discard an in-flight wrong-path fetch).
- FETCH:
  - branch_taken, ready=1: discard rdata; pc<=target; O_valid<=0; O_instruction<=NOP_INSTR; stay FETCH.
  - branch_taken, ready=0: latch pc as in-flight addr; pc<=target; flush IF/ID; go DRAIN.
  - stall, ready=1: buffer rdata and pc+2 in skid; pc<=pc+2; IF/ID holds; go HOLD.
  - stall, ready=0: PC and IF/ID hold.
  - normal, ready=1: IF/ID <= {pc+2, rdata, 1}; pc<=pc+2.
  - normal, ready=0: IF/ID <= bubble {hold PC_plus_two, NOP_INSTR, 0}.
- HOLD:
  - branch_taken: drop skid; pc<=target; flush IF/ID; go FETCH.
  - stall: everything holds.
  - else: IF/ID <= skid contents with valid=1; go FETCH.
- DRAIN:
  - ready=1: response discarded; go FETCH (pc already the target).
  - branch_taken: pc<=new target, regardless of ready.
  - IF/ID stays flushed. in_stall is ignored.
- Flush: forces O_valid=0 and O_instruction=NOP_INSTR even while in_stall=1. O_PC_plus_two is don't-care when O_valid=0 but must not be X after reset.
- Alignment: in_branch_target bit 0 is ignored; pc bit 0 is always 0.
- Reset mid-operation: rst asserted in any state returns immediately (asynchronously) to reset values. O_imem_req goes to 1 in the first cycle after release. Any outstanding memory response is not tracked; the memory model must be reset together with this block.

Test Plan:
- Zero-wait memory, rdata=16'h1111,16'h2222,16'h3333 at addrs 0,2,4 -> O_instruction 1111/2222/3333 on consecutive cycles, O_PC_plus_two 2/4/6, O_valid=1.
- Memory ready every 3rd cycle -> two bubbles (O_valid=0, NOP_INSTR) between valid instructions; O_imem_addr stable while waiting.
- in_stall=1 for 3 cycles arriving with ready=1 on addr 8 -> HOLD, O_imem_req=0, IF/ID unchanged. On release, O_instruction = word@8, O_PC_plus_two=16'h000A, next fetch addr 16'h000A.
- in_branch_taken=1, target=16'h0040, while fetch of 16'h0010 pending (ready=0), ready two cycles later -> DRAIN discards that word. Next request addr=16'h0040, O_valid=0 throughout, then word@0x0040 with PC_plus_two=16'h0042.
- Branch coincident with stall in HOLD -> O_valid=0 next cycle, next request addr = target, buffered word never appears.
- pc=16'hFFFE fetch then rst pulse mid-wait -> O_PC_plus_two=16'h0000 on wrap. Async rst clears outputs before the next edge, and refetch starts at RESET_PC.
